cp0_timer_bank: RTL and testbench
=================================

# cp0_timer_bank

Parametrised multi-channel CP0 timer/interrupt block, successor to the single Count/Compare pair inside the CP0 register file. It provides NTIMER independent counters behind a shared prescaler, each with compare match, one-shot or periodic mode, sticky pending bit and enable mask. It sits beside the CP0 register file: MTC0/MFC0 accesses for timer registers are decoded onto its write/read ports, and `irq_o` feeds the Cause IP hardware-interrupt bits.

## Interface
- NTIMER, 2: number of timer channels (1..8); CH_W = max(1, $clog2(NTIMER)).
- CNT_W, 32: counter and compare width (8..32).
- PRESCALE, 2: cycles per count tick (1..256); PRESCALE=2 matches legacy half-rate Count.
- EN_RST, 'b1: per-channel reset value of CTRL.EN, NTIMER bits.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  freezes prescaler and all counters (debug halt).
- we_i  in  1  register write strobe.
- wsel_i  in  2  write register select: 0 COUNT, 1 COMPARE, 2 CTRL, 3 reserved (ignored).
- wch_i  in  CH_W  write channel.
- data_i  in  CNT_W  write data.
- rsel_i  in  2  read register select, same encoding.
- rch_i  in  CH_W  read channel.
- data_o  out  CNT_W  read data, combinational from current register state.
- count_o  out  NTIMER*CNT_W  all counters, channel i at [i*CNT_W +: CNT_W].
- irq_o  out  NTIMER  per-channel interrupt, pend[i] & ie[i].
- irq_any_o  out  1  OR of irq_o.

## Operation
- CTRL bits: [0] EN, [1] PERIODIC, [2] IE, [3] PEND (read: pending; write 1: clear, write 0: no effect); other bits read 0, writes ignored.
- Prescaler: counter pc in 0..PRESCALE-1, increments each non-stalled cycle, wraps to 0; tick = (pc == PRESCALE-1) & ~stall_i. PRESCALE=1: tick every non-stalled cycle.
- Per channel i with EN=1 and tick: nxt = count+1 mod 2^CNT_W (wraps silently, no interrupt on wrap).
- Match: compare != 0 and nxt == compare -> pend <= 1; if PERIODIC, count <= 0, else count <= nxt (keeps counting past compare).
- compare == 0 disables matching for that channel.
- EN=0: count and pend hold; writes still take effect.
- Write COUNT: count <= data_i. Write COMPARE: compare <= data_i, pend <= 0. Write CTRL: EN/PERIODIC/IE loaded; PEND cleared if data_i[3]=1.
- Out-of-range channel (wch_i >= NTIMER) or wsel_i=3: write dropped. Read of out-of-range channel or rsel_i=3: data_o = 0.
- Reset: pc=0; every count=0, compare=0, pend=0, PERIODIC=0, IE=0, EN=EN_RST[i]. Outputs after reset: count_o=0, irq_o=0, irq_any_o=0; data_o = selected register reset value.

## Timing
- All state updates on rising clk; data_o, irq_o, irq_any_o are combinational from registers (no added latency).
- Read in the same cycle as a write returns the old value; new value visible the cycle after.
- Count tick: after rst deasserts with no stall, first increment on the PRESCALE-th rising edge; then every PRESCALE edges.
- Match: pend and irq_o assert after the same edge at which count reaches compare (or returns to 0 in PERIODIC mode).
- Write COUNT same cycle as tick on that channel: write wins, no increment, no match.
- Write COMPARE same cycle as match: write wins, pend=0.
- CTRL W1C same cycle as match: set wins, pend=1 (no lost interrupt).
- Write CTRL EN=0 same cycle as tick: channel does not count that tick.
- stall_i freezes pc; the tick in progress resumes where it stopped.
- rst asserted mid-count: all state returns to reset values on that edge, overriding writes and matches.

## Test plan
- Reset/prescale (PRESCALE=2, CNT_W=32): release rst, 10 cycles -> count ch0 = 5, ch1 = 0 (EN_RST='b1), irq_o = 0.
- One-shot match: ch0 COMPARE=3, CTRL=IE|EN -> irq_o[0]=1 after edge where count=3; count continues to 4,5; write COMPARE=100 -> irq_o[0]=0 next cycle.
- Periodic: ch1 COMPARE=4, CTRL=EN|PERIODIC|IE -> count 1,2,3,0,1,... pend set at each 0; W1C CTRL=0xF clears, re-sets at next wrap.
- Collisions: COUNT write 0x10 on tick -> count=0x10; CTRL W1C on match cycle -> pend stays 1; COMPARE write on match -> pend 0.
- Wrap/mask: CNT_W=8, COUNT=0xFE, COMPARE=0 -> 0xFF, 0x00, no pend; IE=0 with match -> PEND reads 1, irq_o=0, setting IE -> irq_o=1.
- Stall/reset/out-of-range: stall_i 5 cycles -> count frozen; write wch_i=3 with NTIMER=2 -> no change, read returns 0; rst mid-count -> all zero next cycle.

Source files
------------

// File: rtl/cp0_timer_bank.sv
// Multi-channel CP0 timer bank: shared prescaler and NTIMER counters.
// Each counter has a compare match, one-shot or periodic mode, a sticky pending bit and an interrupt enable.
module cp0_timer_bank #(
    parameter int                NTIMER   = 2,
    parameter int                CNT_W    = 32,
    parameter int                PRESCALE = 2,
    parameter logic [NTIMER-1:0] EN_RST   = 'b1,
    localparam int               CH_W     = (NTIMER > 1) ? $clog2(NTIMER) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_i,
    input  logic                     we_i,
    input  logic [1:0]               wsel_i,
    input  logic [CH_W-1:0]          wch_i,
    input  logic [CNT_W-1:0]         data_i,
    input  logic [1:0]               rsel_i,
    input  logic [CH_W-1:0]          rch_i,
    output logic [CNT_W-1:0]         data_o,
    output logic [NTIMER*CNT_W-1:0]  count_o,
    output logic [NTIMER-1:0]        irq_o,
    output logic                     irq_any_o
);

    localparam int              PC_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PC_W-1:0] PC_LAST  = PC_W'(PRESCALE - 1);
    localparam logic [1:0]      SEL_CNT  = 2'd0;
    localparam logic [1:0]      SEL_CMP  = 2'd1;
    localparam logic [1:0]      SEL_CTRL = 2'd2;

    logic [PC_W-1:0]   r_pc;
    logic [CNT_W-1:0]  r_cnt [NTIMER];
    logic [CNT_W-1:0]  r_cmp [NTIMER];
    logic [NTIMER-1:0] r_en, r_per, r_ie, r_pend;

    logic              w_tick;
    logic [NTIMER-1:0] w_cnt_wr, w_cmp_wr, w_ctl_wr, w_step, w_match;
    logic [CNT_W-1:0]  w_nxt [NTIMER];
    logic [CNT_W-1:0]  w_rd;

    assign w_tick = (r_pc == PC_LAST) && !stall_i;

    // Shared prescaler; a stall freezes it mid-period
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= '0;
        end else if (!stall_i) begin
            r_pc <= (r_pc == PC_LAST) ? '0 : r_pc + PC_W'(1);
        end
    end

    // Write decode and per-channel step/match; a COUNT write or a CTRL write clearing EN suppresses the tick
    always_comb begin
        w_cnt_wr = '0;
        w_cmp_wr = '0;
        w_ctl_wr = '0;
        w_step   = '0;
        w_match  = '0;
        for (int i = 0; i < NTIMER; i++) begin
            w_cnt_wr[i] = we_i && (int'(wch_i) == i) && (wsel_i == SEL_CNT);
            w_cmp_wr[i] = we_i && (int'(wch_i) == i) && (wsel_i == SEL_CMP);
            w_ctl_wr[i] = we_i && (int'(wch_i) == i) && (wsel_i == SEL_CTRL);
            w_nxt[i]    = r_cnt[i] + CNT_W'(1);
            w_step[i]   = w_tick && r_en[i] && !w_cnt_wr[i] && !(w_ctl_wr[i] && !data_i[0]);
            w_match[i]  = w_step[i] && (r_cmp[i] != '0) && (w_nxt[i] == r_cmp[i]);
        end
    end

    // Channel state; match beats a W1C clear, a COMPARE write beats a match
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTIMER; i++) begin
                r_cnt[i] <= '0;
                r_cmp[i] <= '0;
            end
            r_en   <= EN_RST;
            r_per  <= '0;
            r_ie   <= '0;
            r_pend <= '0;
        end else begin
            for (int i = 0; i < NTIMER; i++) begin
                if (w_cnt_wr[i]) begin
                    r_cnt[i] <= data_i;
                end else if (w_step[i]) begin
                    r_cnt[i] <= (w_match[i] && r_per[i]) ? '0 : w_nxt[i];
                end
                if (w_cmp_wr[i]) begin
                    r_cmp[i] <= data_i;
                end
                if (w_ctl_wr[i]) begin
                    r_en[i]  <= data_i[0];
                    r_per[i] <= data_i[1];
                    r_ie[i]  <= data_i[2];
                end
                if (w_cmp_wr[i]) begin
                    r_pend[i] <= 1'b0;
                end else if (w_match[i]) begin
                    r_pend[i] <= 1'b1;
                end else if (w_ctl_wr[i] && data_i[3]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    // Read mux and interrupt outputs, combinational from register state
    always_comb begin
        data_o  = '0;
        count_o = '0;
        w_rd    = '0;
        for (int i = 0; i < NTIMER; i++) begin
            count_o[i*CNT_W +: CNT_W] = r_cnt[i];
            case (rsel_i)
                SEL_CNT:  w_rd = r_cnt[i];
                SEL_CMP:  w_rd = r_cmp[i];
                SEL_CTRL: w_rd = CNT_W'({r_pend[i], r_ie[i], r_per[i], r_en[i]});
                default:  w_rd = '0;
            endcase
            data_o = data_o | ((int'(rch_i) == i) ? w_rd : '0);
        end
        irq_o     = r_pend & r_ie;
        irq_any_o = |(r_pend & r_ie);
    end

endmodule

// File: tb/tb_cp0_timer_bank.sv
// Randomised and directed bench for cp0_timer_bank against a behavioural channel model.
module tb_cp0_timer_bank;

    localparam int           NT    = 3;
    localparam int           CW    = 32;
    localparam int           PS    = 2;
    localparam int           CHW   = 2;
    localparam logic [NT-1:0] EN_R = 3'b001;
    localparam longint unsigned MOD = 64'h1_0000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall_i;
    logic              we_i;
    logic [1:0]        wsel_i;
    logic [CHW-1:0]    wch_i;
    logic [CW-1:0]     data_i;
    logic [1:0]        rsel_i;
    logic [CHW-1:0]    rch_i;
    logic [CW-1:0]     data_o;
    logic [NT*CW-1:0]  count_o;
    logic [NT-1:0]     irq_o;
    logic              irq_any_o;

    cp0_timer_bank #(.NTIMER(NT), .CNT_W(CW), .PRESCALE(PS), .EN_RST(EN_R)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .we_i(we_i), .wsel_i(wsel_i),
        .wch_i(wch_i), .data_i(data_i), .rsel_i(rsel_i), .rch_i(rch_i),
        .data_o(data_o), .count_o(count_o), .irq_o(irq_o), .irq_any_o(irq_any_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: plain integers per channel
    longint unsigned m_cnt [NT];
    longint unsigned m_cmp [NT];
    int m_en [NT];
    int m_per [NT];
    int m_ie [NT];
    int m_pend [NT];
    int m_pc;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc = 0;
        for (int i = 0; i < NT; i++) begin
            m_cnt[i] = 0; m_cmp[i] = 0; m_per[i] = 0; m_ie[i] = 0; m_pend[i] = 0;
            m_en[i] = int'(EN_R[i]);
        end
    endtask

    function automatic logic [CW-1:0] model_read(int sel, int ch);
        if (ch >= NT) return '0;
        case (sel)
            0: return CW'(m_cnt[ch]);
            1: return CW'(m_cmp[ch]);
            2: return CW'(m_pend[ch] * 8 + m_ie[ch] * 4 + m_per[ch] * 2 + m_en[ch]);
            default: return '0;
        endcase
    endfunction

    // One rising edge of the timer rules, applied to the current inputs
    task automatic model_edge();
        int tick, wr, counting, matched;
        longint unsigned nxt;
        if (rst) begin
            model_reset();
            return;
        end
        tick = (!stall_i && m_pc == PS - 1) ? 1 : 0;
        if (!stall_i) m_pc = (m_pc + 1) % PS;
        for (int c = 0; c < NT; c++) begin
            wr = (we_i && wsel_i != 2'd3 && int'(wch_i) == c) ? 1 : 0;
            counting = (tick && m_en[c] && !(wr && wsel_i == 2'd2 && !data_i[0])) ? 1 : 0;
            matched = 0;
            if (counting && !(wr && wsel_i == 2'd0)) begin
                nxt = (m_cnt[c] + 1) % MOD;
                matched = (m_cmp[c] != 0 && nxt == m_cmp[c]) ? 1 : 0;
                m_cnt[c] = (matched && m_per[c]) ? 0 : nxt;
            end
            if (wr) begin
                case (wsel_i)
                    2'd0: m_cnt[c] = longint'(data_i);
                    2'd1: begin m_cmp[c] = longint'(data_i); m_pend[c] = 0; end
                    default: begin
                        m_en[c] = int'(data_i[0]); m_per[c] = int'(data_i[1]); m_ie[c] = int'(data_i[2]);
                        if (data_i[3]) m_pend[c] = 0;
                    end
                endcase
            end
            if (matched && !(wr && wsel_i == 2'd1)) m_pend[c] = 1;
        end
    endtask

    // Called at a falling edge with inputs set; checks the read port, clocks once, checks state outputs
    task automatic cycle();
        logic [NT*CW-1:0] e_cnt;
        logic [NT-1:0]    e_irq;
        #1;
        check("data_o", data_o, model_read(int'(rsel_i), int'(rch_i)));
        model_edge();
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NT; i++) begin
            e_cnt[i*CW +: CW] = CW'(m_cnt[i]);
            e_irq[i] = (m_pend[i] && m_ie[i]) ? 1'b1 : 1'b0;
        end
        check("count_o", count_o, e_cnt);
        check("irq_o", irq_o, e_irq);
        check("irq_any_o", irq_any_o, |e_irq);
    endtask

    task automatic wr(input int sel, input int ch, input logic [CW-1:0] d);
        we_i = 1'b1; wsel_i = 2'(sel); wch_i = CHW'(ch); data_i = d;
        cycle();
        we_i = 1'b0;
    endtask

    task automatic align_tick();
        while (m_pc != PS - 1) cycle();
    endtask

    longint unsigned saved;

    initial begin
        rst = 1'b1; stall_i = 1'b0; we_i = 1'b0; wsel_i = 2'd0; wch_i = '0;
        data_i = '0; rsel_i = 2'd0; rch_i = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        cycle();
        check("rst_count", count_o, 0);
        check("rst_irq", irq_o, 0);
        rst = 1'b0;
        repeat (10) cycle();
        check("presc_ch0", count_o[CW-1:0], 5);
        check("presc_ch1", count_o[2*CW-1:CW], 0);

        // one-shot match on ch0
        wr(0, 0, 0); wr(1, 0, 3); wr(2, 0, 5);
        repeat (8) cycle();
        rsel_i = 2'd2; rch_i = 2'd0; #1;
        check("oneshot_ctrl", data_o, 32'hD);
        wr(1, 0, 100);
        check("oneshot_clr", irq_o[0], 1'b0);

        // periodic on ch1, W1C then re-set at next wrap
        wr(1, 1, 4); wr(2, 1, 7);
        repeat (12) cycle();
        wr(2, 1, 15);
        repeat (10) cycle();

        // collisions
        align_tick(); wr(0, 0, 32'h10);
        check("cnt_wr_tick", count_o[CW-1:0], 32'h10);
        wr(0, 0, 99); align_tick(); wr(2, 0, 32'hD);
        check("w1c_vs_match", irq_o[0], 1'b1);
        wr(0, 0, 99); align_tick(); wr(1, 0, 100);
        check("cmp_vs_match", irq_o[0], 1'b0);

        // wrap with compare disabled, then masked pending on ch2
        wr(1, 2, 0); wr(0, 2, 32'hFFFF_FFFE); wr(2, 2, 1);
        repeat (6) cycle();
        check("wrap_cnt", count_o[3*CW-1:2*CW], 32'h1);
        rsel_i = 2'd2; rch_i = 2'd2; #1;
        check("wrap_nopend", data_o, 32'h1);
        wr(0, 2, 0); wr(1, 2, 2);
        repeat (8) cycle();
        rsel_i = 2'd2; rch_i = 2'd2; #1;
        check("mask_ctrl", data_o, 32'h9);
        check("mask_irq", irq_o[2], 1'b0);
        wr(2, 2, 5);
        check("unmask_irq", irq_o[2], 1'b1);

        // stall, out-of-range access, reset mid-count
        saved = m_cnt[0];
        stall_i = 1'b1;
        repeat (5) cycle();
        check("stall_hold", count_o[CW-1:0], CW'(saved));
        stall_i = 1'b0;
        wr(0, 3, 32'h55);
        rsel_i = 2'd0; rch_i = 2'd3; #1;
        check("oor_read", data_o, 0);
        rsel_i = 2'd3; rch_i = 2'd0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("midrst_count", count_o, 0);
        check("midrst_irq", irq_o, 0);

        // randomised traffic biased toward small values so matches occur
        repeat (800) begin
            rst     = ($urandom_range(0, 63) == 0);
            stall_i = ($urandom_range(0, 9) == 0);
            we_i    = ($urandom_range(0, 2) == 0);
            wsel_i  = 2'($urandom_range(0, 3));
            wch_i   = CHW'($urandom_range(0, 3));
            data_i  = ($urandom_range(0, 3) == 0) ? CW'($urandom) : CW'($urandom_range(0, 9));
            rsel_i  = 2'($urandom_range(0, 3));
            rch_i   = CHW'($urandom_range(0, 3));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
